// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack access sequencer: request codes, stack-pointer
// strobe codes, reset stack pointer and the sequencer's local state encoding.
package stack_seq_pkg;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_PUSH = 3'd1;
  localparam logic [2:0] CMD_POP  = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;

  localparam logic [3:0] RAM_SEL_NONE = 4'h0;
  localparam logic [3:0] WR_RAM_STACK = 4'h1;
  localparam logic [3:0] RD_RAM_STACK = 4'h2;

  localparam logic [7:0] RST_SP = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR1  = 3'd1,
    ST_WR2  = 3'd2,
    ST_RD1  = 3'd3,
    ST_RD2  = 3'd4,
    ST_CAP1 = 3'd5,
    ST_CAP2 = 3'd6
  } state_t;

  function automatic logic cmd_is_valid(input logic [2:0] c);
    return (c == CMD_PUSH) || (c == CMD_POP) || (c == CMD_CALL) || (c == CMD_RET);
  endfunction

  function automatic logic cmd_is_write(input logic [2:0] c);
    return (c == CMD_PUSH) || (c == CMD_CALL);
  endfunction

endpackage

// File: rtl/stack_seq.sv
// Stack access sequencer: turns PUSH/POP/CALL/RET requests into internal-RAM
// cycles addressed from the stack pointer, strobing the pointer in lock-step.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic        flag_clr,
  input  logic [7:0]  ram_rdata,
  output logic [3:0]  ram_sel,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_rd,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pop_data,
  output logic [15:0] pc_out,
  output logic        ovf,
  output logic        udf
);

  if (RD_LAT != 1) begin : g_lat_check
    $error("stack_seq supports RD_LAT=1 only");
  end

  state_t      state_reg, state_next;
  logic [2:0]  cmd_reg;
  logic [7:0]  data_reg;
  logic [15:0] pc_reg;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        we_cyc, rd_cyc;
  logic        done_reg, done_next;
  logic        accept;
  logic [7:0]  pop_reg;
  logic [15:0] pc_out_reg;
  logic [7:0]  sp_inc;
  logic [1:0]  flag_set, flag_reg;

  // Pushes are pre-increment: the target is always one above the live pointer.
  assign sp_inc = sp_in + 8'd1;

  always_comb begin
    state_next = state_reg;
    we_cyc     = 1'b0;
    rd_cyc     = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_is_valid(cmd)) begin
          accept     = 1'b1;
          state_next = cmd_is_write(cmd) ? ST_WR1 : ST_RD1;
        end
      end
      ST_WR1: begin
        we_cyc     = 1'b1;
        addr_next  = sp_inc;
        wdata_next = (cmd_reg == CMD_CALL) ? pc_reg[7:0] : data_reg;
        if (cmd_reg == CMD_CALL) begin
          state_next = ST_WR2;
        end else begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      ST_WR2: begin
        we_cyc     = 1'b1;
        addr_next  = sp_inc;
        wdata_next = pc_reg[15:8];
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      ST_RD1: begin
        rd_cyc     = 1'b1;
        addr_next  = sp_in;
        state_next = (cmd_reg == CMD_RET) ? ST_RD2 : ST_CAP1;
      end
      ST_RD2: begin
        rd_cyc     = 1'b1;
        addr_next  = sp_in;
        state_next = ST_CAP2;
      end
      ST_CAP1, ST_CAP2: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cmd_reg    <= CMD_NOP;
      data_reg   <= 8'h00;
      pc_reg     <= 16'h0000;
      addr_reg   <= 8'h00;
      wdata_reg  <= 8'h00;
      done_reg   <= 1'b0;
      pop_reg    <= 8'h00;
      pc_out_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      if (accept) begin
        cmd_reg  <= cmd;
        data_reg <= cmd_data;
        pc_reg   <= pc_in;
      end
      // Read data trails ram_rd by one clock, so each capture sits one state late.
      if (state_reg == ST_CAP1) pop_reg <= ram_rdata;
      if (state_reg == ST_RD2)  pc_out_reg[15:8] <= ram_rdata;
      if (state_reg == ST_CAP2) pc_out_reg[7:0]  <= ram_rdata;
    end
  end

  // Bit 0 is overflow (write at FFh), bit 1 underflow (read at or below RST_SP).
  assign flag_set[0] = we_cyc && (sp_in == 8'hFF);
  assign flag_set[1] = rd_cyc && (sp_in <= RST_SP);

  for (genvar gi = 0; gi < 2; gi++) begin : g_flag
    logic flag_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        flag_q <= 1'b0;
      end else if (flag_set[gi]) begin
        flag_q <= 1'b1;
      end else if (flag_clr) begin
        flag_q <= 1'b0;
      end
    end
    assign flag_reg[gi] = flag_q;
  end

  assign ram_sel   = we_cyc ? WR_RAM_STACK : (rd_cyc ? RD_RAM_STACK : RAM_SEL_NONE);
  assign ram_we    = we_cyc;
  assign ram_rd    = rd_cyc;
  assign ram_addr  = addr_next;
  assign ram_wdata = wdata_next;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign pop_data  = pop_reg;
  assign pc_out    = pc_out_reg;
  assign ovf       = flag_reg[0];
  assign udf       = flag_reg[1];

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Stack access sequencer: owns the data side of the stack. It turns PUSH/POP/CALL/RET requests from the control unit into internal-RAM write/read cycles addressed from the stack pointer.
- It drives the stack pointer's ram_sel increment/decrement strobes, so pointer and RAM traffic stay in lock-step.
- It returns popped bytes and return addresses (PC) to the core.

Parameters:
- RD_LAT, 1, internal RAM read latency in clocks; only 1 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request strobe; sampled only when busy=0
- cmd  in  3  request code: CMD_NOP, CMD_PUSH, CMD_POP, CMD_CALL, CMD_RET
- cmd_data  in  8  byte to push (CMD_PUSH)
- pc_in  in  16  return address to push (CMD_CALL)
- sp_in  in  8  current stack pointer value from the stack-pointer register
- flag_clr  in  1  clears the sticky overflow/underflow flags
- ram_rdata  in  8  RAM read data, valid one clock after ram_rd
- ram_sel  out  4  stack strobe to the stack pointer: WR_RAM_STACK, RD_RAM_STACK or RAM_SEL_NONE
- ram_addr  out  8  internal RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_rd  out  1  RAM read enable
- busy  out  1  high from accept through the last RAM cycle
- done  out  1  one-clock completion pulse
- pop_data  out  8  byte returned by CMD_POP
- pc_out  out  16  address returned by CMD_RET
- ovf  out  1  sticky: a push was issued with sp_in=8'hFF
- udf  out  1  sticky: a pop was issued with sp_in<=RST_SP (8'h07)

Behaviour:
- Reset (async): state=IDLE; ram_sel=RAM_SEL_NONE; ram_we=ram_rd=busy=done=0; ram_addr=ram_wdata=pop_data=0; pc_out=16'h0000; ovf=udf=0.
- States: IDLE, WR1, WR2, RD1, RD2, CAP1, CAP2.
- Accept: in IDLE, cmd_valid=1 with a non-NOP cmd latches cmd, cmd_data and pc_in. Next state is WR1 (PUSH, CALL) or RD1 (POP, RET). NOP and invalid codes are ignored (no done).
- Stack discipline is pre-increment push, post-decrement pop. The stack pointer updates on the clock edge at the end of each strobed cycle.
- WR1:
  - Drives ram_we=1, ram_sel=WR_RAM_STACK, ram_addr=sp_in+1 (mod 256).
  - ram_wdata = cmd_data for PUSH, pc[7:0] for CALL.
  - Next state: PUSH -> IDLE with done=1 the following cycle; CALL -> WR2.
- WR2 (CALL only): ram_we=1, ram_sel=WR_RAM_STACK, ram_addr=sp_in+1, ram_wdata=pc[15:8]; -> IDLE with done.
- RD1:
  - Drives ram_rd=1, ram_sel=RD_RAM_STACK, ram_addr=sp_in.
  - Next state: POP -> CAP1; RET -> RD2.
- RD2 (RET only): ram_rd=1, ram_sel=RD_RAM_STACK, ram_addr=sp_in (already decremented); captures ram_rdata into pc_out[15:8]; -> CAP2.
- CAP1: pop_data <= ram_rdata; -> IDLE with done.
- CAP2: pc_out[7:0] <= ram_rdata; -> IDLE with done.
- Latency (accept edge to done high): PUSH 2 clocks, CALL 3, POP 3, RET 4. done is high for exactly one cycle, in IDLE. A new cmd may be accepted in that same cycle.
- Outside strobed cycles: ram_sel=RAM_SEL_NONE; ram_we=ram_rd=0. ram_addr and ram_wdata hold their last value.
- busy=1 in every state except IDLE.
- Wrap-around:
  - Push at sp_in=8'hFF writes address 8'h00 and sets ovf; the stack pointer wraps as it does natively.
  - Pop at sp_in<=8'h07 still reads sp_in and still strobes RD; the stack pointer clamps at 07h. udf is set.
  - Each byte of CALL/RET is checked independently.
- Flags: ovf/udf stay set until flag_clr. If flag_clr and a set condition occur in the same cycle, set wins.
- Reset mid-operation: aborts immediately to the reset values. A partially pushed CALL is not undone.
- cmd_valid while busy=1 is ignored; the requester must hold the request until busy=0.

Decomposition:
- Shared define file (define_opcodes.v) gains:
  - CMD_NOP=3'd0, CMD_PUSH=3'd1, CMD_POP=3'd2, CMD_CALL=3'd3, CMD_RET=3'd4
  - RAM_SEL_NONE, alongside the existing WR_RAM_STACK, RD_RAM_STACK and RST_SP
  - State encodings, localised to this block
- No sub-module; a single FSM with a small datapath.

Test Plan:
- Reset, then PUSH cmd_data=8'hA5 with sp_in=8'h07 -> one cycle of ram_we=1, ram_addr=8'h08, ram_wdata=8'hA5, ram_sel=WR_RAM_STACK; done 2 clocks after accept; ovf=0.
- CALL pc_in=16'h1234 with sp_in tracking 07h -> writes 8'h34 @08h, then 8'h12 @09h on consecutive cycles; two WR strobes; busy for 2 cycles.
- RET with sp_in=09h, RAM[09h]=8'h12, RAM[08h]=8'h34 -> reads 09h then 08h; pc_out=16'h1234 at done; two RD strobes.
- POP with sp_in=8'h07 -> reads 07h, udf=1, pop_data=RAM[07h]; flag_clr then clears udf to 0.
- PUSH with sp_in=8'hFF -> ram_addr=8'h00, ovf=1; back-to-back PUSH accepted in the done cycle completes correctly.
- Assert reset in RD2 of a RET -> all outputs return to reset values in the same cycle; next POP behaves normally.
